// File: rtl/gate_response_checker_if.sv
// Stimulus handshake between the basic-gates stimulus source and the response checker.
// The master drives a vector and the gates block's response; the checker reports readiness.
interface gate_response_checker_if;
  logic       vec_valid;
  logic       vec_ready;
  logic [3:0] vec_in;
  logic [6:0] dut_out;

  modport master (output vec_valid, vec_in, dut_out, input vec_ready);
  modport slave  (input vec_valid, vec_in, dut_out, output vec_ready);
endinterface

// File: rtl/gate_response_checker.sv
// Response checker for the basic-gates block: accept vector, settle, compare, accumulate stats.
// Optional input-coverage map enabled by defining GATE_CHECK_COVERAGE_EN.
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  gate_response_checker_if.slave stim,
  output logic                   result_valid_o,
  output logic [6:0]             mismatch_mask_o,
  output logic [CNT_W-1:0]       vec_count_o,
  output logic [CNT_W-1:0]       err_count_o,
  output logic [3:0]             first_fail_vec_o,
  output logic [6:0]             first_fail_mask_o,
  output logic                   fail_seen_o,
  output logic                   pass_o
`ifdef GATE_CHECK_COVERAGE_EN
  ,
  output logic [15:0]            cov_map_o,
  output logic                   cov_full_o
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [3:0]      vec_q, vec_d;
  logic            rv_q, rv_d;
  logic [6:0]      mask_q, mask_d;
  logic [CNT_W-1:0] vc_q, vc_d, ec_q, ec_d;
  logic [3:0]      ffv_q, ffv_d;
  logic [6:0]      ffm_q, ffm_d;
  logic            fs_q, fs_d;
`ifdef GATE_CHECK_COVERAGE_EN
  logic [15:0]     cov_q, cov_d;
`endif

  logic       accept;
  logic       is_check;
  logic [6:0] check_mask;

  // {not(in_1), and, or, nand, nor, xor, xnor}; in_1 is the MSB of the vector
  function automatic logic [6:0] golden(input logic [3:0] v);
    return {~v[3], &v, |v, ~&v, ~|v, ^v, ~^v};
  endfunction

  assign stim.vec_ready = (state_q == IDLE);
  assign accept         = stim.vec_valid & stim.vec_ready & ~clear_i;
  assign is_check       = (state_q == CHECK);
  assign check_mask     = stim.dut_out ^ golden(vec_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: if (accept) begin
        vec_d = stim.vec_in;
        cnt_d = SW'(SETTLE_CYCLES);
        if (SETTLE_CYCLES == 0) state_d = CHECK;
        else                    state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = CHECK;
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Statistics; clear wins over a CHECK in the same cycle so an aborted vector is never counted
  always_comb begin
    rv_d   = is_check;
    mask_d = mask_q;
    vc_d   = vc_q;
    ec_d   = ec_q;
    ffv_d  = ffv_q;
    ffm_d  = ffm_q;
    fs_d   = fs_q;
`ifdef GATE_CHECK_COVERAGE_EN
    cov_d  = cov_q;
`endif
    if (is_check) begin
      mask_d = check_mask;
      if (vc_q != CNT_MAX) vc_d = vc_q + CNT_W'(1);
      if (|check_mask) begin
        if (ec_q != CNT_MAX) ec_d = ec_q + CNT_W'(1);
        if (!fs_q) begin
          ffv_d = vec_q;
          ffm_d = check_mask;
          fs_d  = 1'b1;
        end
      end
`ifdef GATE_CHECK_COVERAGE_EN
      cov_d[vec_q] = 1'b1;
`endif
    end
    if (clear_i) begin
      rv_d   = 1'b0;
      mask_d = '0;
      vc_d   = '0;
      ec_d   = '0;
      ffv_d  = '0;
      ffm_d  = '0;
      fs_d   = 1'b0;
`ifdef GATE_CHECK_COVERAGE_EN
      cov_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      rv_q    <= 1'b0;
      mask_q  <= '0;
      vc_q    <= '0;
      ec_q    <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
      fs_q    <= 1'b0;
`ifdef GATE_CHECK_COVERAGE_EN
      cov_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      rv_q    <= rv_d;
      mask_q  <= mask_d;
      vc_q    <= vc_d;
      ec_q    <= ec_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
      fs_q    <= fs_d;
`ifdef GATE_CHECK_COVERAGE_EN
      cov_q   <= cov_d;
`endif
    end
  end

  assign result_valid_o    = rv_q;
  assign mismatch_mask_o   = mask_q;
  assign vec_count_o       = vc_q;
  assign err_count_o       = ec_q;
  assign first_fail_vec_o  = ffv_q;
  assign first_fail_mask_o = ffm_q;
  assign fail_seen_o       = fs_q;
  assign pass_o            = (vc_q != '0) && (ec_q == '0);
`ifdef GATE_CHECK_COVERAGE_EN
  assign cov_map_o  = cov_q;
  assign cov_full_o = &cov_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: table vectors, randomized traffic against a behavioural
// model, clear/abort sequences, counter saturation on a narrow instance, optional coverage map.
module tb_gate_response_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_a, clear_b;
  always #5 clk = ~clk;

  gate_response_checker_if ifa ();
  gate_response_checker_if ifb ();

  logic       a_rv, a_fs, a_pass;
  logic [6:0] a_mask, a_ffm;
  logic [7:0] a_vc, a_ec;
  logic [3:0] a_ffv;
  logic       b_rv, b_fs, b_pass;
  logic [6:0] b_mask, b_ffm;
  logic [3:0] b_vc, b_ec;
  logic [3:0] b_ffv;
`ifdef GATE_CHECK_COVERAGE_EN
  logic [15:0] a_cov, b_cov;
  logic        a_covf, b_covf;
`endif

  gate_response_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .stim(ifa.slave),
    .result_valid_o(a_rv), .mismatch_mask_o(a_mask), .vec_count_o(a_vc), .err_count_o(a_ec),
    .first_fail_vec_o(a_ffv), .first_fail_mask_o(a_ffm), .fail_seen_o(a_fs), .pass_o(a_pass)
`ifdef GATE_CHECK_COVERAGE_EN
    , .cov_map_o(a_cov), .cov_full_o(a_covf)
`endif
  );

  gate_response_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_b), .stim(ifb.slave),
    .result_valid_o(b_rv), .mismatch_mask_o(b_mask), .vec_count_o(b_vc), .err_count_o(b_ec),
    .first_fail_vec_o(b_ffv), .first_fail_mask_o(b_ffm), .fail_seen_o(b_fs), .pass_o(b_pass)
`ifdef GATE_CHECK_COVERAGE_EN
    , .cov_map_o(b_cov), .cov_full_o(b_covf)
`endif
  );

  int n_tot  = 0;
  int n_pass = 0;

  // behavioural model of the statistics of instance A
  int         m_vc, m_ec;
  logic [3:0] m_ffv;
  logic [6:0] m_ffm, m_mask;
  bit         m_fs;

  typedef struct {
    logic [3:0] vec;
    logic [6:0] dut;
    logic [6:0] exp_mask;
  } vec_t;
  vec_t tbl [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [6:0] gold(input logic [3:0] v);
    int n;
    n = $countones(v);
    return {~v[3], (v == 4'hF), (v != 4'h0), (v != 4'hF), (v == 4'h0), (n % 2 == 1), (n % 2 == 0)};
  endfunction

  task automatic model_clear();
    m_vc = 0; m_ec = 0; m_ffv = '0; m_ffm = '0; m_mask = '0; m_fs = 0;
  endtask

  task automatic model_result(input logic [3:0] v, input logic [6:0] d);
    m_mask = d ^ gold(v);
    if (m_vc < 255) m_vc++;
    if (m_mask != 0) begin
      if (m_ec < 255) m_ec++;
      if (!m_fs) begin m_fs = 1; m_ffv = v; m_ffm = m_mask; end
    end
  endtask

  task automatic check_state_a(input string tag);
    chk({tag, ".mask"}, a_mask, m_mask);
    chk({tag, ".vec_count"}, a_vc, m_vc);
    chk({tag, ".err_count"}, a_ec, m_ec);
    chk({tag, ".ff_vec"}, a_ffv, m_ffv);
    chk({tag, ".ff_mask"}, a_ffm, m_ffm);
    chk({tag, ".fail_seen"}, a_fs, m_fs);
    chk({tag, ".pass"}, a_pass, (m_vc != 0) && (m_ec == 0));
  endtask

  // One vector through A; returns in the result_valid cycle (IDLE, so the next send is back-to-back)
  task automatic send_a(input logic [3:0] v, input logic [6:0] d, input string tag);
    bit lat_ok;
    int w;
    ifa.vec_in = v; ifa.dut_out = d; ifa.vec_valid = 1'b1;
    w = 0;
    while (ifa.vec_ready !== 1'b1 && w < 10) begin tick(); w++; end
    chk({tag, ".ready_before_accept"}, ifa.vec_ready, 1'b1);
    tick();
    ifa.vec_valid = 1'b0;
    lat_ok = 1;
    for (int k = 1; k <= 3; k++) begin
      if (ifa.vec_ready !== 1'b0 || a_rv !== 1'b0) lat_ok = 0;
      tick();
    end
    if (a_rv !== 1'b1 || ifa.vec_ready !== 1'b1) lat_ok = 0;
    chk({tag, ".latency"}, lat_ok, 1'b1);
    model_result(v, d);
    check_state_a(tag);
  endtask

  // Accept a vector, then clear during cycle k after acceptance (1..2 SETTLE, 3 CHECK)
  task automatic abort_a(input logic [3:0] v, input int k, input string tag);
    ifa.vec_in = v; ifa.dut_out = ~gold(v); ifa.vec_valid = 1'b1;
    tick();
    ifa.vec_valid = 1'b0;
    for (int j = 1; j < k; j++) tick();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    model_clear();
    chk({tag, ".rv_after_clear"}, a_rv, 1'b0);
    chk({tag, ".ready_after_clear"}, ifa.vec_ready, 1'b1);
    check_state_a(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    ifa.vec_valid = 1'b0; ifa.vec_in = '0; ifa.dut_out = '0;
    ifb.vec_valid = 1'b0; ifb.vec_in = '0; ifb.dut_out = '0;
    model_clear();

    tbl[0] = '{4'b0001, 7'b1011010, 7'b0000000};
    tbl[1] = '{4'b1111, 7'b0110011, 7'b0000010};
    tbl[2] = '{4'b0000, 7'b0000000, 7'b1001101};
    tbl[3] = '{4'b1010, 7'b0011001, 7'b0000000};
    tbl[4] = '{4'b0110, 7'b1111111, 7'b0100110};

    // reset
    tick(); tick();
    chk("reset.rv_mask_counts", {a_rv, a_mask, a_vc, a_ec}, '0);
    chk("reset.ff_flags", {a_ffv, a_ffm, a_fs, a_pass}, '0);
    rst_n = 1'b1;
    tick();
    chk("post_reset.ready", ifa.vec_ready, 1'b1);
    chk("post_reset.pass", a_pass, 1'b0);

    // table vectors (first is the correct-response case, then fault injection)
    for (int i = 0; i < 5; i++) begin
      send_a(tbl[i].vec, tbl[i].dut, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_mask", i), a_mask, tbl[i].exp_mask);
    end
    chk("tbl.first_fail_vec", a_ffv, 4'b1111);
    chk("tbl.first_fail_mask", a_ffm, 7'b0000010);
    chk("tbl.err_count", a_ec, 8'd3);
    tick();
    chk("tbl.rv_one_cycle", a_rv, 1'b0);
    chk("tbl.mask_holds", a_mask, 7'b0100110);

    // clear in the first SETTLE cycle aborts uncounted; the next good vector counts as the first
    abort_a(4'b0011, 1, "clr_mid");
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("clr_mid.no_rv", a_rv, 1'b0);
    end
    send_a(4'b0101, gold(4'b0101), "clr_next");
    chk("clr_next.vec_count", a_vc, 8'd1);

    // handshake coinciding with clear is dropped
    ifa.vec_valid = 1'b1; clear_a = 1'b1;
    tick();
    ifa.vec_valid = 1'b0; clear_a = 1'b0; model_clear();
    chk("clr_idle.ready", ifa.vec_ready, 1'b1);
    check_state_a("clr_idle");

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int r, gap;
      logic [3:0] v;
      logic [6:0] d;
      r = $urandom_range(0, 19);
      v = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      if (r == 0) abort_a(v, $urandom_range(1, 3), "rnd_abort");
      else if (r == 1) begin
        clear_a = 1'b1; ifa.vec_valid = 1'b1;
        tick();
        clear_a = 1'b0; ifa.vec_valid = 1'b0; model_clear();
        chk("rnd_clr_idle.ready", ifa.vec_ready, 1'b1);
        check_state_a("rnd_clr_idle");
      end else begin
        d = gold(v);
        if ($urandom_range(0, 1) == 1) d = d ^ (7'd1 << $urandom_range(0, 6));
        if ($urandom_range(0, 7) == 0) d = 7'($urandom_range(0, 127));
        send_a(v, d, "rnd");
      end
    end

    // saturation on the 4-bit instance: 17 passes, then failures with valid held high
    begin
      int nres, nacc, last_acc, cyc;
      bit spacing_ok, done;
      nres = 0; nacc = 0; last_acc = -1; cyc = 0; spacing_ok = 1; done = 0;
      ifb.vec_in = 4'hF; ifb.dut_out = gold(4'hF); ifb.vec_valid = 1'b1;
      while (!done && cyc < 400) begin
        if (b_rv === 1'b1) begin
          nres++;
          if (nres == 17) begin
            chk("sat.pass_vc", b_vc, 4'd15);
            chk("sat.pass_ec", b_ec, 4'd0);
            chk("sat.pass_flag", b_pass, 1'b1);
            ifb.dut_out = 7'b0000000;
          end
          if (nres == 20) begin
            chk("sat.ec_while_vc_sat", b_ec, 4'd3);
            chk("sat.vc_held", b_vc, 4'd15);
          end
          if (nres == 37) begin ifb.vec_valid = 1'b0; done = 1; end
        end
        if (ifb.vec_valid === 1'b1 && ifb.vec_ready === 1'b1) begin
          if (last_acc >= 0 && cyc - last_acc != 4) spacing_ok = 0;
          last_acc = cyc;
          nacc++;
        end
        tick();
        cyc++;
      end
      chk("sat.finished_in_budget", done, 1'b1);
      chk("sat.accept_spacing", spacing_ok, 1'b1);
      chk("sat.accepts", nacc, 37);
      tick(); tick(); tick(); tick();
      chk("sat.vc_no_wrap", b_vc, 4'd15);
      chk("sat.ec_no_wrap", b_ec, 4'd15);
      chk("sat.fail_seen", b_fs, 1'b1);
      chk("sat.pass_low", b_pass, 1'b0);
    end

`ifdef GATE_CHECK_COVERAGE_EN
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0; model_clear();
    chk("cov.cleared", a_cov, 16'h0);
    for (int v = 0; v < 16; v++) begin
      send_a(4'(v), gold(4'(v)), "cov");
      if (v == 14) chk("cov.not_full_yet", a_covf, 1'b0);
    end
    chk("cov.map_full", a_cov, 16'hFFFF);
    chk("cov.full", a_covf, 1'b1);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk("cov.map_after_clear", a_cov, 16'h0);
    chk("cov.full_after_clear", a_covf, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
